// File: rtl/pmips_pkg.sv
// Shared definitions for the pmips core and its program-memory controller.
// Contents: arbiter state encoding, instruction width/NOP, major opcodes.
package pmips_pkg;

    localparam int unsigned INSTR_W = 16;
    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    // Major opcodes, instruction bits [15:13]
    localparam logic [2:0] BEQ  = 3'd2;
    localparam logic [2:0] ADDI = 3'd3;
    localparam logic [2:0] LW   = 3'd5;
    localparam logic [2:0] SW   = 3'd6;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        DRAIN   = 3'd1,
        BOOT    = 3'd2,
        LOAD    = 3'd3,
        RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit saturating event counter with synchronous clear.
// Ports: clock/reset (async, active-high), clear, inc, count.
module sat_counter16 (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/imem_arb.sv
// Single-port program memory controller shared by CPU fetch and host loader.
// Ports: clock/reset; cpu_* fetch side (iaddr in, idata/ivalid/stall/restart
// out); ld_* loader side (req/wr/rd/addr/wdata in, gnt/rdata/ack/err/count
// out); mem_* synchronous SRAM side (en/we/addr/wdata out, rdata in).
module imem_arb
    import pmips_pkg::*;
#(
    parameter int unsigned AW              = 5,
    parameter bit          BOOT_HOLD       = 1'b0,
    parameter bit          RESTART_ON_LOAD = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [15:0]        cpu_iaddr,
    output logic [INSTR_W-1:0] cpu_idata,
    output logic               cpu_ivalid,
    output logic               cpu_stall,
    output logic               cpu_restart,
    input  logic               ld_req,
    output logic               ld_gnt,
    input  logic               ld_wr,
    input  logic               ld_rd,
    input  logic [15:0]        ld_addr,
    input  logic [15:0]        ld_wdata,
    output logic [15:0]        ld_rdata,
    output logic               ld_ack,
    output logic               ld_err,
    output logic [15:0]        ld_count,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [15:0]        mem_wdata,
    input  logic [15:0]        mem_rdata
);

    state_t state, next_state;

    logic ld_oor, fetch_oor;
    logic load_act, strobe_acc, wr_acc, rd_acc;
    logic ivalid_q, fetch_oor_q, ack_q, err_q, rd_q;
    logic unused_byte_bits;

    // Memory is word addressed; byte-lane bit 0 of both address buses is dropped.
    assign unused_byte_bits = cpu_iaddr[0] ^ ld_addr[0];

    assign ld_oor    = |ld_addr[15:AW+1];
    assign fetch_oor = |cpu_iaddr[15:AW+1];

    // Strobes count only while granted and the loader still holds its request.
    assign load_act   = (state == LOAD) && ld_req;
    assign strobe_acc = load_act && (ld_wr || ld_rd);
    assign wr_acc     = load_act && ld_wr && !ld_oor;
    assign rd_acc     = load_act && ld_rd && !ld_wr && !ld_oor;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= BOOT_HOLD ? BOOT : RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (ld_req) next_state = DRAIN;
            DRAIN:   next_state = LOAD;
            BOOT:    if (ld_req) next_state = LOAD;
            LOAD:    if (!ld_req) next_state = RELEASE;
            RELEASE: next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // FSM outputs; held at zero while reset is asserted
    always_comb begin
        cpu_stall   = 1'b0;
        cpu_restart = 1'b0;
        ld_gnt      = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        if (!reset) begin
            case (state)
                RUN: begin
                    mem_en   = 1'b1;
                    mem_addr = cpu_iaddr[AW:1];
                end
                DRAIN, BOOT: begin
                    cpu_stall = 1'b1;
                end
                LOAD: begin
                    cpu_stall = 1'b1;
                    ld_gnt    = 1'b1;
                    mem_en    = wr_acc || rd_acc;
                    mem_we    = wr_acc;
                    mem_addr  = ld_addr[AW:1];
                    mem_wdata = wr_acc ? ld_wdata : 16'h0000;
                end
                RELEASE: begin
                    cpu_stall   = 1'b1;
                    cpu_restart = RESTART_ON_LOAD;
                end
                default: begin
                    cpu_stall = 1'b1;
                end
            endcase
        end
    end

    // Completion tracking for the one-cycle memory latency on both sides
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ivalid_q    <= 1'b0;
            fetch_oor_q <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            ivalid_q    <= (state == RUN);
            fetch_oor_q <= fetch_oor;
            ack_q       <= strobe_acc;
            err_q       <= strobe_acc && ld_oor;
            rd_q        <= rd_acc;
        end
    end

    assign cpu_ivalid = ivalid_q;
    assign cpu_idata  = (ivalid_q && !fetch_oor_q) ? mem_rdata : NOP;
    assign ld_ack     = ack_q;
    assign ld_err     = err_q;
    assign ld_rdata   = rd_q ? mem_rdata : 16'h0000;

    // Write count clears on entry to LOAD and holds after the session ends
    sat_counter16 u_ld_count (
        .clock (clock),
        .reset (reset),
        .clear ((next_state == LOAD) && (state != LOAD)),
        .inc   (wr_acc),
        .count (ld_count)
    );

endmodule

// File: tb/tb_imem_arb.sv
// Bench for imem_arb: directed loader/CPU sequence with an ack scoreboard,
// plus a BOOT_HOLD=1 instance exercising the boot-time stall.
module tb_imem_arb;
    import pmips_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] cpu_iaddr;
    logic [15:0] cpu_idata;
    logic        cpu_ivalid, cpu_stall, cpu_restart;
    logic        ld_req, ld_gnt, ld_wr, ld_rd;
    logic [15:0] ld_addr, ld_wdata, ld_rdata;
    logic        ld_ack, ld_err;
    logic [15:0] ld_count;
    logic        mem_en, mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic        ld_req_b;
    logic [15:0] b_idata, b_rdata, b_count, b_wdata;
    logic        b_ivalid, b_stall, b_restart, b_gnt, b_ack, b_err, b_en, b_we;
    logic [4:0]  b_addr;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem    [32];
    logic [15:0] shadow [32];
    logic [15:0] prog   [9];

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
    } ack_t;
    ack_t exp_q[$];

    always #5 clock = ~clock;

    imem_arb #(.AW(5), .BOOT_HOLD(1'b0), .RESTART_ON_LOAD(1'b1)) dut (
        .clock(clock), .reset(reset),
        .cpu_iaddr(cpu_iaddr), .cpu_idata(cpu_idata), .cpu_ivalid(cpu_ivalid),
        .cpu_stall(cpu_stall), .cpu_restart(cpu_restart),
        .ld_req(ld_req), .ld_gnt(ld_gnt), .ld_wr(ld_wr), .ld_rd(ld_rd),
        .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_rdata(ld_rdata),
        .ld_ack(ld_ack), .ld_err(ld_err), .ld_count(ld_count),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    imem_arb #(.AW(5), .BOOT_HOLD(1'b1), .RESTART_ON_LOAD(1'b1)) dut_boot (
        .clock(clock), .reset(reset),
        .cpu_iaddr(cpu_iaddr), .cpu_idata(b_idata), .cpu_ivalid(b_ivalid),
        .cpu_stall(b_stall), .cpu_restart(b_restart),
        .ld_req(ld_req_b), .ld_gnt(b_gnt), .ld_wr(1'b0), .ld_rd(1'b0),
        .ld_addr(16'h0000), .ld_wdata(16'h0000), .ld_rdata(b_rdata),
        .ld_ack(b_ack), .ld_err(b_err), .ld_count(b_count),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(16'h0000)
    );

    // Synchronous single-port memory, one-cycle read latency
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Ack scoreboard: every ld_ack must match the oldest pending strobe
    always @(negedge clock) begin
        if (!reset && ld_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("ack_unexpected", 16'(ld_ack), 16'h0000);
            end else begin
                ack_t e;
                e = exp_q.pop_front();
                check("ack_err", 16'(ld_err), 16'(e.err));
                check("ack_rdata", ld_rdata, e.rdata);
            end
        end
    end

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rs,
                                        input logic [2:0] rt, input logic [6:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic is_oor(input logic [15:0] a);
        return |a[15:6];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ack_t e;
        ld_wr = 1'b1; ld_rd = 1'b0; ld_addr = a; ld_wdata = d;
        e.err = is_oor(a); e.rdata = 16'h0000;
        exp_q.push_back(e);
        if (!is_oor(a)) shadow[a[5:1]] = d;
    endtask

    task automatic rd(input logic [15:0] a);
        ack_t e;
        ld_wr = 1'b0; ld_rd = 1'b1; ld_addr = a;
        e.err = is_oor(a);
        e.rdata = is_oor(a) ? 16'h0000 : shadow[a[5:1]];
        exp_q.push_back(e);
    endtask

    task automatic idle();
        ld_wr = 1'b0; ld_rd = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mem[i]    = 16'hA000 + 16'(i);
            shadow[i] = 16'hA000 + 16'(i);
        end
        mem[2] = 16'h62A0; shadow[2] = 16'h62A0;
        // 3 x 5 by repeated addition
        prog[0] = enc(ADDI, 3'd0, 3'd1, 7'd3);
        prog[1] = enc(ADDI, 3'd0, 3'd2, 7'd5);
        prog[2] = enc(ADDI, 3'd0, 3'd3, 7'd0);
        prog[3] = enc(BEQ,  3'd2, 3'd0, 7'd3);
        prog[4] = enc(ADDI, 3'd3, 3'd3, 7'd3);
        prog[5] = enc(ADDI, 3'd2, 3'd2, 7'h7F);
        prog[6] = enc(BEQ,  3'd0, 3'd0, 7'h7C);
        prog[7] = enc(SW,   3'd0, 3'd3, 7'd0);
        prog[8] = enc(LW,   3'd0, 3'd4, 7'd0);

        reset = 1'b1; cpu_iaddr = 16'h0000; ld_req = 1'b0; ld_req_b = 1'b0;
        ld_wr = 1'b0; ld_rd = 1'b0; ld_addr = 16'h0000; ld_wdata = 16'h0000;

        #2;
        check("rst_mem_en", 16'(mem_en), 16'h0000);
        check("rst_stall", 16'(cpu_stall), 16'h0000);
        check("rst_gnt", 16'(ld_gnt), 16'h0000);
        check("rst_count", ld_count, 16'h0000);
        check("rst_ivalid", 16'(cpu_ivalid), 16'h0000);
        check("rst_b_stall", 16'(b_stall), 16'h0000);

        tick(); tick();
        reset = 1'b0; cpu_iaddr = 16'h0004;
        @(negedge clock);
        check("fetch_mem_addr", 16'(mem_addr), 16'h0002);
        check("fetch_mem_en", 16'(mem_en), 16'h0001);
        check("run_stall", 16'(cpu_stall), 16'h0000);
        check("boot_hold_stall", 16'(b_stall), 16'h0001);
        check("boot_hold_gnt", 16'(b_gnt), 16'h0000);

        tick();
        @(negedge clock);
        check("fetch_idata", cpu_idata, 16'h62A0);
        check("fetch_ivalid", 16'(cpu_ivalid), 16'h0001);
        check("fetch_stall", 16'(cpu_stall), 16'h0000);

        // Session 1: grant latency, write/read/out-of-range/both strobes
        tick(); ld_req = 1'b1;
        @(negedge clock);
        check("pre_k_stall", 16'(cpu_stall), 16'h0000);
        tick();
        @(negedge clock);
        check("drain_stall", 16'(cpu_stall), 16'h0001);
        check("drain_gnt", 16'(ld_gnt), 16'h0000);
        check("drain_mem_en", 16'(mem_en), 16'h0000);
        check("drain_ivalid", 16'(cpu_ivalid), 16'h0001);
        tick(); wr(16'h0000, 16'h6103);
        @(negedge clock);
        check("load_gnt", 16'(ld_gnt), 16'h0001);
        check("wr_mem_we", 16'(mem_we), 16'h0001);
        check("wr_mem_addr", 16'(mem_addr), 16'h0000);
        check("wr_mem_wdata", mem_wdata, 16'h6103);
        tick(); rd(16'h0000);
        @(negedge clock);
        check("count_after_wr", ld_count, 16'h0001);
        check("rd_mem_we", 16'(mem_we), 16'h0000);
        check("rd_mem_en", 16'(mem_en), 16'h0001);
        tick(); wr(16'h0040, 16'h1234);
        @(negedge clock);
        check("oor_mem_en", 16'(mem_en), 16'h0000);
        check("count_after_rd", ld_count, 16'h0001);
        tick(); wr(16'h0002, 16'h1111); ld_rd = 1'b1;
        @(negedge clock);
        check("both_mem_we", 16'(mem_we), 16'h0001);
        check("count_after_oor", ld_count, 16'h0001);
        tick(); rd(16'h0002);
        @(negedge clock);
        check("count_after_both", ld_count, 16'h0002);
        tick(); ld_req = 1'b0; ld_wr = 1'b1; ld_rd = 1'b0; ld_addr = 16'h0004;
        @(negedge clock);
        check("drop_req_mem_we", 16'(mem_we), 16'h0000);
        tick(); idle();
        @(negedge clock);
        check("rel_gnt", 16'(ld_gnt), 16'h0000);
        check("rel_restart", 16'(cpu_restart), 16'h0001);
        check("rel_stall", 16'(cpu_stall), 16'h0001);
        check("rel_count_hold", ld_count, 16'h0002);
        check("rel_no_ack", 16'(ld_ack), 16'h0000);
        tick(); ld_wr = 1'b1; ld_addr = 16'h0000;
        @(negedge clock);
        check("run2_stall", 16'(cpu_stall), 16'h0000);
        check("run2_restart", 16'(cpu_restart), 16'h0000);
        check("ungranted_mem_we", 16'(mem_we), 16'h0000);
        tick(); idle(); ld_req = 1'b1;
        @(negedge clock);
        check("ungranted_no_ack", 16'(ld_ack), 16'h0000);

        // Session 2: nine program writes, read-back, release
        tick(); tick();
        wr(16'h0000, prog[0]);
        @(negedge clock);
        check("s2_count_clear", ld_count, 16'h0000);
        for (int i = 1; i < 9; i++) begin
            tick(); wr(16'(2 * i), prog[i]);
        end
        tick(); rd(16'h0008);
        tick(); idle(); ld_req = 1'b0;
        @(negedge clock);
        check("s2_count9", ld_count, 16'h0009);
        tick();
        @(negedge clock);
        check("s2_rel_restart", 16'(cpu_restart), 16'h0001);
        check("s2_rel_stall", 16'(cpu_stall), 16'h0001);
        check("s2_rel_count", ld_count, 16'h0009);
        tick(); cpu_iaddr = 16'h0008; ld_req_b = 1'b1;
        @(negedge clock);
        check("s2_run_stall", 16'(cpu_stall), 16'h0000);
        check("s2_boot_stall", 16'(b_stall), 16'h0001);
        tick(); ld_req_b = 1'b0;
        @(negedge clock);
        check("prog_fetch", cpu_idata, shadow[4]);
        check("prog_ivalid", 16'(cpu_ivalid), 16'h0001);
        check("b_load_gnt", 16'(b_gnt), 16'h0001);
        check("b_load_stall", 16'(b_stall), 16'h0001);
        cpu_iaddr = 16'h0040;
        tick();
        @(negedge clock);
        check("b_rel_restart", 16'(b_restart), 16'h0001);
        check("b_rel_stall", 16'(b_stall), 16'h0001);
        tick();
        @(negedge clock);
        check("oor_fetch_idata", cpu_idata, 16'h0000);
        check("oor_fetch_ivalid", 16'(cpu_ivalid), 16'h0001);
        check("b_run_stall", 16'(b_stall), 16'h0000);

        // Session 3: reset lands mid-session with a write strobe active
        cpu_iaddr = 16'h0000;
        tick(); ld_req = 1'b1;
        tick(); tick(); wr(16'h0006, 16'h5555);
        @(negedge clock);
        check("s3_mem_we", 16'(mem_we), 16'h0001);
        tick();
        ld_addr = 16'h0008; ld_wdata = 16'h7777;
        @(negedge clock);
        check("s3_ack_before_rst", 16'(ld_ack), 16'h0001);
        #2 reset = 1'b1;
        #1;
        check("arst_mem_we", 16'(mem_we), 16'h0000);
        check("arst_gnt", 16'(ld_gnt), 16'h0000);
        check("arst_ack", 16'(ld_ack), 16'h0000);
        check("arst_stall", 16'(cpu_stall), 16'h0000);
        check("arst_count", ld_count, 16'h0000);
        idle(); ld_req = 1'b0;
        tick(); reset = 1'b0;
        @(negedge clock);
        check("post_rst_stall", 16'(cpu_stall), 16'h0000);
        check("post_rst_gnt", 16'(ld_gnt), 16'h0000);
        check("post_rst_count", ld_count, 16'h0000);
        check("post_rst_mem_en", 16'(mem_en), 16'h0001);
        check("post_rst_b_stall", 16'(b_stall), 16'h0001);
        tick();
        @(negedge clock);
        check("post_rst_ack", 16'(ld_ack), 16'h0000);
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
